// File: rtl/motoro3_step_sequencer.sv
// Six-step commutation sequencer for a BLDC motor: holds the rotor aligned,
// runs the 1..6 commutation sequence at a programmable step period, then brakes.
module motoro3_step_sequencer #(
  parameter int ALIGN_PERIODS = 16,
  parameter int BRAKE_PERIODS = 8
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        m3r_run,
  input  logic        m3r_dir,
  input  logic [24:0] m3r_stepCNT_speedSET,
  output logic [3:0]  m3step,
  output logic [24:0] m3cnt,
  output logic        m3cntLast1,
  output logic        m3stepPulse,
  output logic        m3busy
);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN,
    BRAKE
  } state_t;

  localparam logic [3:0]  STEP_OFF   = 4'd0;
  localparam logic [3:0]  STEP_FIRST = 4'd1;
  localparam logic [3:0]  STEP_LAST  = 4'd6;
  localparam logic [3:0]  STEP_BRAKE = 4'd8;
  localparam logic [24:0] PERIOD_MIN = 25'd2;

  localparam int PC_MAX = (ALIGN_PERIODS > BRAKE_PERIODS) ? ALIGN_PERIODS : BRAKE_PERIODS;
  localparam int PC_W   = (PC_MAX < 2) ? 1 : $clog2(PC_MAX + 1);

  localparam logic [PC_W-1:0] ALIGN_LAST = PC_W'(ALIGN_PERIODS - 1);
  localparam logic [PC_W-1:0] BRAKE_LAST = PC_W'(BRAKE_PERIODS - 1);

  state_t          state, state_nxt;
  logic [24:0]     period, period_nxt, period_set;
  logic [PC_W-1:0] pcnt, pcnt_nxt;
  logic [24:0]     cnt_nxt;
  logic [3:0]      step_nxt, step_adv;
  logic            pulse_nxt;
  logic            busy_nxt;
  logic            wrap;

  // Periods below 2 would make the first and last cycle coincide.
  assign period_set = (m3r_stepCNT_speedSET < PERIOD_MIN) ? PERIOD_MIN : m3r_stepCNT_speedSET;

  assign wrap       = (state != IDLE) && (m3cnt == period - 25'd1);
  assign m3cntLast1 = wrap;

  always_comb begin
    step_adv = STEP_FIRST;
    if (m3r_dir) begin
      step_adv = (m3step <= STEP_FIRST) ? STEP_LAST : m3step - 4'd1;
    end else begin
      step_adv = (m3step >= STEP_LAST) ? STEP_FIRST : m3step + 4'd1;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = m3cnt;
    step_nxt   = m3step;
    pcnt_nxt   = pcnt;
    period_nxt = period;
    pulse_nxt  = 1'b0;

    if (state == IDLE) begin
      cnt_nxt  = '0;
      step_nxt = STEP_OFF;
      if (m3r_run) begin
        state_nxt  = ALIGN;
        step_nxt   = STEP_FIRST;
        pcnt_nxt   = '0;
        period_nxt = period_set;
        pulse_nxt  = 1'b1;
      end
    end else if (wrap) begin
      cnt_nxt    = '0;
      period_nxt = period_set;
      pulse_nxt  = 1'b1;
      unique case (state)
        ALIGN: begin
          if (!m3r_run) begin
            state_nxt = BRAKE;
            step_nxt  = STEP_BRAKE;
            pcnt_nxt  = '0;
          end else if (pcnt == ALIGN_LAST) begin
            state_nxt = RUN;
            step_nxt  = step_adv;
            pcnt_nxt  = '0;
          end else begin
            pcnt_nxt = pcnt + 1'b1;
          end
        end
        RUN: begin
          if (!m3r_run) begin
            state_nxt = BRAKE;
            step_nxt  = STEP_BRAKE;
            pcnt_nxt  = '0;
          end else begin
            step_nxt = step_adv;
          end
        end
        BRAKE: begin
          // Run requests are ignored here: the brake always completes first.
          if (pcnt == BRAKE_LAST) begin
            state_nxt = IDLE;
            step_nxt  = STEP_OFF;
            pcnt_nxt  = '0;
            pulse_nxt = 1'b0;
          end else begin
            pcnt_nxt = pcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          step_nxt  = STEP_OFF;
        end
      endcase
    end else begin
      cnt_nxt = m3cnt + 25'd1;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state       <= IDLE;
      m3step      <= STEP_OFF;
      m3cnt       <= '0;
      m3stepPulse <= 1'b0;
      m3busy      <= 1'b0;
      period      <= PERIOD_MIN;
      pcnt        <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state       <= state_nxt;
      m3step      <= step_nxt;
      m3cnt       <= cnt_nxt;
      m3stepPulse <= pulse_nxt;
      m3busy      <= busy_nxt;
      period      <= period_nxt;
      pcnt        <= pcnt_nxt;
    end
  end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Self-checking bench for motoro3_step_sequencer: a cycle model derived from the
// sequencing rules is compared every cycle, plus hand-computed directed checks.
module tb_motoro3_step_sequencer;

  localparam int ALIGN_P = 2;
  localparam int BRAKE_P = 2;

  logic        clk = 1'b0;
  logic        nrst;
  logic        run;
  logic        dir;
  logic [24:0] spd;
  logic [3:0]  m3step;
  logic [24:0] m3cnt;
  logic        m3cntLast1;
  logic        m3stepPulse;
  logic        m3busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  motoro3_step_sequencer #(
    .ALIGN_PERIODS(ALIGN_P),
    .BRAKE_PERIODS(BRAKE_P)
  ) dut (
    .clk                  (clk),
    .nRst                 (nrst),
    .m3r_run              (run),
    .m3r_dir              (dir),
    .m3r_stepCNT_speedSET (spd),
    .m3step               (m3step),
    .m3cnt                (m3cnt),
    .m3cntLast1           (m3cntLast1),
    .m3stepPulse          (m3stepPulse),
    .m3busy               (m3busy)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 align, 2 run, 3 brake; idx selects commutation step idx+1.
  int m_mode = 0, m_cnt = 0, m_p = 2, m_n = 0, m_idx = 0, m_pulse = 0;

  function automatic int clamp_p(input logic [24:0] s);
    return (s < 2) ? 2 : int'(s);
  endfunction

  function automatic int m_step();
    if (m_mode == 0) return 0;
    if (m_mode == 3) return 8;
    return m_idx + 1;
  endfunction

  always @(posedge clk) begin
    if (!nrst) begin
      m_mode = 0; m_cnt = 0; m_p = 2; m_n = 0; m_idx = 0; m_pulse = 0;
    end else if (m_mode == 0) begin
      m_pulse = 0;
      if (run) begin
        m_mode = 1; m_idx = 0; m_cnt = 0; m_n = 0; m_p = clamp_p(spd); m_pulse = 1;
      end
    end else if (m_cnt == m_p - 1) begin
      m_cnt = 0; m_p = clamp_p(spd); m_pulse = 1; m_n++;
      if (m_mode != 3 && !run) begin
        m_mode = 3; m_n = 0;
      end else if (m_mode == 1 && m_n == ALIGN_P) begin
        m_mode = 2; m_idx = dir ? (m_idx + 5) % 6 : (m_idx + 1) % 6;
      end else if (m_mode == 2) begin
        m_idx = dir ? (m_idx + 5) % 6 : (m_idx + 1) % 6;
      end else if (m_mode == 3 && m_n == BRAKE_P) begin
        m_mode = 0; m_pulse = 0;
      end
    end else begin
      m_cnt++; m_pulse = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model m3step", 32'(m3step), 32'(m_step()));
      check("model m3cnt", 32'(m3cnt), 32'(m_cnt));
      check("model m3cntLast1", 32'(m3cntLast1), 32'((m_mode != 0) && (m_cnt == m_p - 1)));
      check("model m3stepPulse", 32'(m3stepPulse), 32'(m_pulse));
      check("model m3busy", 32'(m3busy), 32'(m_mode != 0));
    end
  end

  task automatic wait_sc(input logic [3:0] s, input logic [24:0] c);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m3step == s && m3cnt == c) found = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("reach step %0d cnt %0d", s, c), 32'(found), 32'd1);
  endtask

  logic [3:0]  rs [80];
  logic [24:0] rc [80];
  logic        rl [80];
  logic        rp [80];

  initial begin
    nrst = 1'b0; run = 1'b0; dir = 1'b0; spd = 25'd10;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset m3step", 32'(m3step), 0);
    check("reset m3cnt", 32'(m3cnt), 0);
    check("reset m3busy", 32'(m3busy), 0);
    check("reset m3stepPulse", 32'(m3stepPulse), 0);
    check("reset m3cntLast1", 32'(m3cntLast1), 0);

    // Start: 20 cycles of step 1, then 2,3,4,5,6,1 at 10 cycles each.
    nrst = 1'b1; run = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      rs[i] = m3step; rc[i] = m3cnt; rl[i] = m3cntLast1; rp[i] = m3stepPulse;
    end
    for (int i = 0; i < 80; i++) begin
      check($sformatf("start step[%0d]", i), 32'(rs[i]),
            (i < 20) ? 1 : (((i - 20) / 10 + 1) % 6) + 1);
      check($sformatf("start cnt[%0d]", i), 32'(rc[i]), i % 10);
      check($sformatf("start last1[%0d]", i), 32'(rl[i]), 32'(i % 10 == 9));
      check($sformatf("start pulse[%0d]", i), 32'(rp[i]), 32'(i % 10 == 0));
    end

    // Direction change mid-period only applies at the boundary.
    wait_sc(4'd3, 25'd4);
    dir = 1'b1;
    repeat (5) @(negedge clk);
    check("dir step held", 32'(m3step), 3);
    check("dir last1", 32'(m3cntLast1), 1);
    @(negedge clk);
    check("dir reversed step", 32'(m3step), 2);
    check("dir pulse", 32'(m3stepPulse), 1);

    // Speed change mid-period only applies at the boundary.
    wait_sc(4'd2, 25'd5);
    spd = 25'd20;
    repeat (4) @(negedge clk);
    check("speed old period end", 32'(m3cnt), 9);
    check("speed old last1", 32'(m3cntLast1), 1);
    @(negedge clk);
    check("speed new step", 32'(m3step), 1);
    repeat (19) @(negedge clk);
    check("speed new period end", 32'(m3cnt), 19);
    check("speed new last1", 32'(m3cntLast1), 1);
    check("speed step held", 32'(m3step), 1);
    @(negedge clk);
    check("speed next step", 32'(m3step), 6);
    spd = 25'd10;

    // Stop mid-period: finish the step, brake 2 periods of 10, then idle.
    wait_sc(4'd5, 25'd0);
    wait_sc(4'd5, 25'd3);
    run = 1'b0;
    repeat (6) @(negedge clk);
    check("stop step held", 32'(m3step), 5);
    check("stop cnt", 32'(m3cnt), 9);
    @(negedge clk);
    check("brake step", 32'(m3step), 8);
    check("brake busy", 32'(m3busy), 1);
    run = 1'b1;
    repeat (19) @(negedge clk);
    check("brake last step", 32'(m3step), 8);
    check("brake last cnt", 32'(m3cnt), 9);
    run = 1'b0;
    @(negedge clk);
    check("idle step", 32'(m3step), 0);
    check("idle busy", 32'(m3busy), 0);

    // Period clamp: speed 0 and 1 both give a 2-cycle period.
    spd = 25'd0; run = 1'b1;
    @(negedge clk);
    check("clamp align step", 32'(m3step), 1);
    check("clamp cnt0", 32'(m3cnt), 0);
    @(negedge clk);
    check("clamp cnt1", 32'(m3cnt), 1);
    check("clamp last1", 32'(m3cntLast1), 1);
    spd = 25'd1;
    @(negedge clk);
    check("clamp wrap cnt", 32'(m3cnt), 0);
    check("clamp wrap pulse", 32'(m3stepPulse), 1);
    repeat (3) @(negedge clk);
    check("clamp1 cnt", 32'(m3cnt), 1);

    // Reset mid-run takes effect immediately; held run restarts through ALIGN.
    wait_sc(4'd5, 25'd0);
    nrst = 1'b0;
    @(negedge clk);
    check("rst run step", 32'(m3step), 0);
    check("rst run cnt", 32'(m3cnt), 0);
    check("rst run busy", 32'(m3busy), 0);
    nrst = 1'b1;
    @(negedge clk);
    check("restart step", 32'(m3step), 1);
    check("restart busy", 32'(m3busy), 1);
    check("restart pulse", 32'(m3stepPulse), 1);

    repeat (5) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(100 * 20000);
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/motoro3_step_sequencer.md
MOTORO3_STEP_SEQUENCER -- requirements
Module: motoro3_step_sequencer

Interface
REQ-001 SHALL have parameter ALIGN_PERIODS, default 16, meaning number of step periods the rotor is held at step 1 before running.
REQ-002 SHALL have parameter BRAKE_PERIODS, default 8, meaning number of step periods step 8 (all low-side on) is held on stop.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  system clock, 10 MHz.
REQ-005 nRst  input  1  synchronous active-low reset.
REQ-006 m3r_run  input  1  level; 1 = motor requested running, 0 = stop requested.
REQ-007 m3r_dir  input  1  0 = forward (step 1->6), 1 = reverse (step 6->1).
REQ-008 m3r_stepCNT_speedSET  input  25  clk cycles per commutation step.
REQ-009 m3step  output  4  commutation step to the line generators: 0 off, 1..6 commutation, 8 brake.
REQ-010 m3cnt  output  25  position inside the current step period.
REQ-011 m3cntLast1  output  1  high on the last cycle of a step period.
REQ-012 m3stepPulse  output  1  one-cycle strobe on the first cycle of every new step period.
REQ-013 m3busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, ALIGN, RUN, BRAKE.
REQ-015 SHALL keep m3cnt at 0, m3cntLast1 at 0, m3step at 0 in IDLE.
REQ-016 SHALL, in ALIGN/RUN/BRAKE, increment m3cnt each clk and wrap to 0 after value P-1, where P is the latched period.
REQ-017 SHALL latch P from m3r_stepCNT_speedSET on IDLE exit and at every wrap; speed changes take effect only at a period boundary.
REQ-018 SHALL clamp P to 2 when m3r_stepCNT_speedSET < 2.
REQ-019 SHALL drive m3cntLast1 combinationally high exactly when m3cnt == P-1 and state != IDLE.
REQ-020 SHALL assert m3stepPulse on the cycle m3cnt == 0 following IDLE exit or a wrap.
REQ-021 IDLE -> ALIGN when m3r_run == 1; next cycle m3step = 1, m3cnt = 0, period counter = 0.
REQ-022 ALIGN: period counter increments at each wrap; after ALIGN_PERIODS wraps -> RUN, m3step advances one step in m3r_dir direction.
REQ-023 RUN: at each wrap m3step advances: forward 1,2,3,4,5,6,1...; reverse 6,5,4,3,2,1,6...
REQ-024 SHALL sample m3r_dir only at a wrap; direction change mid-period has no effect until the next boundary.
REQ-025 ALIGN or RUN with m3r_run == 0 at a wrap -> BRAKE; m3step = 8 from the next cycle, period counter = 0.
REQ-026 SHALL ignore m3r_run deassertion mid-period (stop takes effect only at period boundary).
REQ-027 BRAKE: after BRAKE_PERIODS wraps -> IDLE regardless of m3r_run; m3r_run == 1 in BRAKE is ignored until IDLE.
REQ-028 SHALL never let m3step take values 7 or 9..15.
REQ-029 SHALL hold the period counter wide enough for max(ALIGN_PERIODS, BRAKE_PERIODS) without overflow.
REQ-030 SHALL register all outputs except m3cntLast1.

Reset
REQ-031 On nRst == 0 at a clk edge: state IDLE, m3step 0, m3cnt 0, m3stepPulse 0, m3busy 0, P 2, period counter 0.
REQ-032 Reset asserted mid-RUN or mid-BRAKE SHALL take effect on the same edge, no brake phase executed.

Verification
REQ-033 Reset, run=1, speedSET=10, ALIGN_PERIODS=2 -> m3step=1 for 20 cycles, then 2,3,4,5,6,1 each for 10 cycles; m3cntLast1 at m3cnt=9.
REQ-034 RUN forward at step 3, dir=1 set at m3cnt=4 -> step 3 completes full period, next step 2.
REQ-035 speedSET 10 -> 20 at m3cnt=5 -> current period ends at m3cnt=9, next period counts 0..19.
REQ-036 run=0 at m3cnt=3 in RUN, BRAKE_PERIODS=2, P=10 -> step unchanged to m3cnt=9, then m3step=8 for 20 cycles, then IDLE, m3step=0, m3busy=0.
REQ-037 speedSET=0 and 1 -> P clamped to 2, m3cnt toggles 0,1, m3cntLast1 every second cycle.
REQ-038 nRst=0 during RUN at step 5 -> next edge m3step=0, m3cnt=0, m3busy=0; run=1 held -> restart via ALIGN.
